// File: rtl/tof_pkg.sv
// ============================================================================
//  Module : tof_pkg
//  Brief  : Shared widths and FSM state encoding for the TOF averaging path.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package tof_pkg;

  // Default TDC result width (LSB = one phase tap).
  localparam int TOF_W_DEF = 13;

  // Width of the saturating reject counter.
  localparam int REJ_W = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CAPTURE  = 2'd1,
    CLEAR    = 2'd2,
    WAIT_LOW = 2'd3
  } tof_state_t;

endpackage

`default_nettype wire

// File: rtl/sync_edge.sv
// ============================================================================
//  Module : sync_edge
//  Brief  : 2-flop synchroniser for an asynchronous level flag plus a third
//           flop for rising-edge detection.
//  Ports  : clk      system clock
//           rst      async reset, active high
//           i_async  asynchronous level input
//           o_level  synchronised level (second flop)
//           o_rise   single-cycle pulse on a synchronised 0->1 transition
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_level,
  output logic o_rise
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_async;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_level = r_s2;
  assign o_rise  = r_s2 & ~r_s3;

endmodule

`default_nettype wire

// File: rtl/tof_accum.sv
// ============================================================================
//  Module : tof_accum
//  Brief  : Captures single-shot TDC results, offset-corrects and range-gates
//           them, averages 2**LOG2_N accepted shots and presents the result
//           on a valid/ready port. Re-arms the TDC after every capture.
//  Ports  : clk, rst              clock / async active-high reset
//           tof_in, tof_valid     TDC result and its (async) level valid
//           cal_offset            calibration offset, sampled in CAPTURE
//           tdc_clr               re-arm pulse, CLR_CYCLES long
//           avg_out, avg_valid,   averaged result with valid/ready handshake
//           avg_ready
//           reject_cnt            saturating count of gated-out shots
//           ovf                   sticky: an average was dropped
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tof_accum
  import tof_pkg::*;
#(
  parameter int TOF_W      = TOF_W_DEF,
  parameter int LOG2_N     = 3,
  parameter int CLR_CYCLES = 4,
  parameter int TOF_MIN    = 0,
  parameter int TOF_MAX    = 8000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [TOF_W-1:0] tof_in,
  input  logic             tof_valid,
  input  logic [TOF_W-1:0] cal_offset,
  output logic             tdc_clr,
  output logic [TOF_W-1:0] avg_out,
  output logic             avg_valid,
  input  logic             avg_ready,
  output logic [REJ_W-1:0] reject_cnt,
  output logic             ovf
);

  localparam int c_acc_w = TOF_W + LOG2_N;
  localparam int c_cnt_w = LOG2_N + 1;
  localparam int c_clr_w = $clog2(CLR_CYCLES + 1);

  localparam logic [c_cnt_w-1:0] c_last_shot = c_cnt_w'((1 << LOG2_N) - 1);
  localparam logic [c_clr_w-1:0] c_clr_last  = c_clr_w'(CLR_CYCLES - 1);
  localparam logic [TOF_W-1:0]   c_tof_min   = TOF_W'(TOF_MIN);
  localparam logic [TOF_W-1:0]   c_tof_max   = TOF_W'(TOF_MAX);
  localparam logic [REJ_W-1:0]   c_rej_sat   = {REJ_W{1'b1}};

  // --------------------------------------------------------------------------
  // Valid synchronisation
  // --------------------------------------------------------------------------
  logic w_valid_lvl;
  logic w_valid_rise;

  sync_edge u_sync_valid (
    .clk     (clk),
    .rst     (rst),
    .i_async (tof_valid),
    .o_level (w_valid_lvl),
    .o_rise  (w_valid_rise)
  );

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  tof_state_t         r_state;
  tof_state_t         w_state_nxt;
  logic [c_clr_w-1:0] r_clr_cnt;
  logic               w_tdc_clr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tdc_clr   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_valid_rise) begin
          w_state_nxt = CAPTURE;
        end
      end
      CAPTURE: begin
        w_state_nxt = CLEAR;
      end
      CLEAR: begin
        w_tdc_clr = 1'b1;
        if (r_clr_cnt == c_clr_last) begin
          w_state_nxt = WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        // The TDC's valid must be seen low before re-arming, otherwise one
        // long level pulse would be captured twice.
        if (!w_valid_lvl) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clr_cnt <= '0;
    end else if (r_state == CLEAR) begin
      r_clr_cnt <= r_clr_cnt + c_clr_w'(1);
    end else begin
      r_clr_cnt <= '0;
    end
  end

  assign tdc_clr = w_tdc_clr;

  // --------------------------------------------------------------------------
  // Offset correction and range gate
  // --------------------------------------------------------------------------
  // One extra bit catches tof_in < cal_offset as a borrow.
  logic [TOF_W:0]   w_diff;
  logic [TOF_W-1:0] w_corr;
  logic             w_under;
  logic             w_below_min;
  logic             w_above_max;
  logic             w_accept;

  assign w_diff  = {1'b0, tof_in} - {1'b0, cal_offset};
  assign w_corr  = w_diff[TOF_W-1:0];
  assign w_under = w_diff[TOF_W];

  // A zero lower bound can never be violated by an unsigned value.
  generate
    if (TOF_MIN == 0) begin : g_no_min
      assign w_below_min = 1'b0;
    end else begin : g_min_chk
      assign w_below_min = (w_corr < c_tof_min);
    end
  endgenerate

  assign w_above_max = (w_corr > c_tof_max);
  assign w_accept    = ~w_under & ~w_below_min & ~w_above_max;

  // --------------------------------------------------------------------------
  // Accumulator, shot count, reject count
  // --------------------------------------------------------------------------
  logic [c_acc_w-1:0] r_acc;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_done;
  logic [REJ_W-1:0]   r_rej;
  logic [TOF_W-1:0]   w_avg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc  <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
      r_rej  <= '0;
    end else begin
      r_done <= 1'b0;
      if (r_done) begin
        // Window complete: average is taken from r_acc this cycle.
        r_acc <= '0;
        r_cnt <= '0;
      end else if (r_state == CAPTURE) begin
        if (w_accept) begin
          r_acc <= r_acc + c_acc_w'(w_corr);
          r_cnt <= r_cnt + c_cnt_w'(1);
          if (r_cnt == c_last_shot) begin
            r_done <= 1'b1;
          end
        end else if (r_rej != c_rej_sat) begin
          r_rej <= r_rej + REJ_W'(1);
        end
      end
    end
  end

  assign w_avg      = TOF_W'(r_acc >> LOG2_N);
  assign reject_cnt = r_rej;

  // --------------------------------------------------------------------------
  // Output register
  // --------------------------------------------------------------------------
  logic [TOF_W-1:0] r_avg_out;
  logic             r_avg_valid;
  logic             r_ovf;
  logic             w_xfer;

  assign w_xfer = r_avg_valid & avg_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_avg_out   <= '0;
      r_avg_valid <= 1'b0;
      r_ovf       <= 1'b0;
    end else if (r_done) begin
      // A transfer in the same cycle frees the register for the new value.
      if (!r_avg_valid || w_xfer) begin
        r_avg_out   <= w_avg;
        r_avg_valid <= 1'b1;
      end else begin
        r_ovf <= 1'b1;
      end
    end else if (w_xfer) begin
      r_avg_valid <= 1'b0;
    end
  end

  assign avg_out   = r_avg_out;
  assign avg_valid = r_avg_valid;
  assign ovf       = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_tof_accum.sv
// ============================================================================
//  Module : tb_tof_accum
//  Brief  : Scoreboard bench for tof_accum with a behavioural average model.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_tof_accum;

  localparam int N     = 8;
  localparam int MINV  = 0;
  localparam int MAXV  = 8000;
  localparam int CLR_N = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [12:0] tof_in;
  logic        tof_valid;
  logic [12:0] cal_offset;
  logic        tdc_clr;
  logic [12:0] avg_out;
  logic        avg_valid;
  logic        avg_ready;
  logic [7:0]  reject_cnt;
  logic        ovf;

  tof_accum dut (
    .clk        (clk),
    .rst        (rst),
    .tof_in     (tof_in),
    .tof_valid  (tof_valid),
    .cal_offset (cal_offset),
    .tdc_clr    (tdc_clr),
    .avg_out    (avg_out),
    .avg_valid  (avg_valid),
    .avg_ready  (avg_ready),
    .reject_cnt (reject_cnt),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int exp_q[$];
  int m_sum = 0;
  int m_cnt = 0;
  int m_rej = 0;
  int m_ovf = 0;
  int ready_mode = 2;   // 0 random, 1 held low, 2 held high

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference model: average of the accepted shots of each full window.
  // A completed window whose predecessor is still unread is lost.
  task automatic model_shot(input int tof, input int off);
    int corr;
    corr = tof - off;
    if (tof < off || corr < MINV || corr > MAXV) begin
      if (m_rej < 255) m_rej++;
    end else begin
      m_sum += corr;
      m_cnt++;
      if (m_cnt == N) begin
        if (exp_q.size() != 0) m_ovf = 1;
        else exp_q.push_back(m_sum / N);
        m_sum = 0;
        m_cnt = 0;
      end
    end
  endtask

  // Emulates the TDC: result held with valid high until re-armed by tdc_clr,
  // optionally holding valid for extra cycles afterwards.
  task automatic shot(input int tof, input int off, input int hold);
    int width;
    int extra;
    bit seen;
    model_shot(tof, off);
    tof_in     = 13'(tof);
    cal_offset = 13'(off);
    tof_valid  = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      cycles(1);
      if (tdc_clr) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_cmp++;
      n_err++;
      $display("FAIL clr_timeout: got no tdc_clr expected a pulse (t=%0t)", $time);
    end else begin
      width = 0;
      for (int i = 0; i < 50 && tdc_clr; i++) begin
        width++;
        cycles(1);
      end
      check("clr_width", width, CLR_N);
    end
    extra = 0;
    for (int i = 0; i < hold; i++) begin
      cycles(1);
      if (tdc_clr) extra++;
    end
    if (hold > 0) check("no_retrigger", extra, 0);
    tof_valid = 1'b0;
    cycles(6);
    check("reject_cnt", int'(reject_cnt), m_rej);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) cycles(1);
    check(name, exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_avg_out"},   int'(avg_out), 0);
    check({tag, "_avg_valid"}, int'(avg_valid), 0);
    check({tag, "_tdc_clr"},   int'(tdc_clr), 0);
    check({tag, "_reject"},    int'(reject_cnt), 0);
    check({tag, "_ovf"},       int'(ovf), 0);
  endtask

  // Consumer ready driver
  initial begin
    avg_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       avg_ready = 1'($urandom_range(0, 1));
        1:       avg_ready = 1'b0;
        default: avg_ready = 1'b1;
      endcase
    end
  end

  // Monitor: compares every transfer against the scoreboard queue and
  // checks that a stalled output holds its value.
  initial begin
    bit         prev_stall;
    logic [12:0] prev_out;
    prev_stall = 1'b0;
    prev_out   = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (avg_valid && prev_stall) check("avg_hold", int'(avg_out), int'(prev_out));
        if (avg_valid && avg_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL spurious_avg: got avg_out=%0d expected no transfer (t=%0t)",
                     avg_out, $time);
          end else begin
            check("avg_out", int'(avg_out), exp_q.pop_front());
          end
        end
        prev_stall = avg_valid && !avg_ready;
        prev_out   = avg_out;
      end
    end
  end

  initial begin
    int tof;
    int off;
    rst        = 1'b1;
    tof_in     = '0;
    tof_valid  = 1'b0;
    cal_offset = '0;
    cycles(3);
    check_reset_outputs("rst0");
    rst = 1'b0;
    cycles(2);

    // 1: eight shots of 100 with offset 4
    ready_mode = 2;
    for (int i = 0; i < N; i++) shot(100, 4, 0);
    drain("t1_drain");

    // 2: truncating average of 10/11
    for (int i = 0; i < N; i++) shot(10 + (i % 2), 0, 0);
    drain("t2_drain");

    // 3: underflow and over-range rejects, then a full window;
    // 4: the first good shot holds valid for 50 cycles
    shot(2, 4, 0);
    shot(8005, 4, 0);
    check("t3_reject2", int'(reject_cnt), 2);
    shot(1000, 0, 50);
    for (int i = 1; i < N; i++) shot(1000 + 3 * i, 0, 0);
    shot(MAXV + 7, 7, 0);  // exactly at upper bound: accepted
    for (int i = 1; i < N; i++) shot(7, 7, 0);  // corrected 0: accepted
    drain("t3_drain");

    // 5: backpressure across two windows
    ready_mode = 1;
    cycles(2);
    for (int i = 0; i < 2 * N; i++) shot(500 + i, 0, 0);
    check("t5_ovf", int'(ovf), m_ovf);
    check("t5_valid_held", int'(avg_valid), 1);
    ready_mode = 2;
    drain("t5_drain");
    cycles(3);
    check("t5_valid_low", int'(avg_valid), 0);

    // 6: reset mid-window discards partial data
    for (int i = 0; i < 5; i++) shot(300, 0, 0);
    rst = 1'b1;
    m_sum = 0;
    m_cnt = 0;
    m_rej = 0;
    m_ovf = 0;
    #2;
    check_reset_outputs("rst1");
    cycles(2);
    rst = 1'b0;
    cycles(2);
    for (int i = 0; i < N; i++) shot(200, 0, 0);
    drain("t6_drain");

    // Randomised traffic with random consumer backpressure
    ready_mode = 0;
    for (int i = 0; i < 64; i++) begin
      off = int'($urandom_range(0, 190));
      case ($urandom_range(0, 7))
        0:       tof = int'($urandom_range(0, 189)) % (off + 1) - 1;
        1:       tof = off + MAXV + 1 + int'($urandom_range(0, 190 - off));
        default: tof = off + int'($urandom_range(0, MAXV));
      endcase
      if (tof < 0) tof = 0;
      shot(tof, off, int'($urandom_range(0, 3)));
    end
    ready_mode = 2;
    drain("rand_drain");
    check("rand_ovf", int'(ovf), m_ovf);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
